fetch_stage: RTL and testbench

- Instruction-fetch stage of the 8-bit pipelined RISC core.
- Owns the program counter and drives the address of the combinational instruction memory.
- Captures the returned byte into the IF/ID pipeline register for the decode stage.
- Handles decode-stage stalls, branch/jump redirects (with bubble insertion) and a HALT instruction.

---
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, fills the IF/ID register.
// Handles decode stalls, branch/jump redirects with one bubble, and HALT.
module fetch_stage #(
  parameter int unsigned   PC_W       = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [7:0]    HALT_INSTR = 8'hFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] imem_pc,
  input  logic [7:0]      imem_instr,
  output logic [7:0]      id_instr,
  output logic [PC_W-1:0] id_pc,
  output logic            id_valid,
  output logic            halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]      instr;
    logic [PC_W-1:0] pc;
    logic            valid;
  } if_id_t;

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  if_id_t          ifid, ifid_n;
  logic            halted_n;

  logic do_redir, do_stall, do_go;

  assign do_redir = redirect_valid;
  assign do_stall = !redirect_valid && stall;
  assign do_go    = !redirect_valid && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      ifid   <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      ifid   <= ifid_n;
      halted <= halted_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ifid_n   = ifid;
    halted_n = halted;
    unique case (state)
      BOOT: begin
        state_n = RUN;
        if (do_redir) begin
          pc_n         = redirect_pc;
          ifid_n.instr = 8'h00;
          ifid_n.valid = 1'b0;
        end
      end
      RUN: begin
        unique case (1'b1)
          do_redir: begin
            pc_n         = redirect_pc;
            ifid_n.instr = 8'h00;
            ifid_n.valid = 1'b0;
          end
          do_stall: ;
          do_go: begin
            ifid_n.instr = imem_instr;
            ifid_n.pc    = pc;
            ifid_n.valid = 1'b1;
            if (imem_instr == HALT_INSTR) begin
              halted_n = 1'b1;
              state_n  = HALT;
            end else begin
              pc_n = pc + 1'b1;
            end
          end
          default: ;
        endcase
      end
      HALT: begin
        unique case (1'b1)
          do_redir: begin
            pc_n         = redirect_pc;
            ifid_n.instr = 8'h00;
            ifid_n.valid = 1'b0;
            halted_n     = 1'b0;
            state_n      = RUN;
          end
          // HALT stays presented until decode accepts it
          do_stall: ;
          do_go: begin
            ifid_n.instr = 8'h00;
            ifid_n.valid = 1'b0;
          end
          default: ;
        endcase
      end
      default: state_n = BOOT;
    endcase
  end

  assign imem_pc  = pc;
  assign id_instr = ifid.instr;
  assign id_pc    = ifid.pc;
  assign id_valid = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a combinational byte memory.
// Observed vector: {halted, id_valid, id_instr, id_pc, imem_pc}.
module tb_fetch_stage;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic [7:0] imem_pc;
  logic [7:0] imem_instr;
  logic [7:0] id_instr;
  logic [7:0] id_pc;
  logic       id_valid;
  logic       halted;

  logic [7:0] mem [0:255];
  int errors = 0;
  int checks = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_valid       (id_valid),
    .halted         (halted)
  );

  assign imem_instr = mem[imem_pc];

  wire [25:0] obs = {halted, id_valid, id_instr, id_pc, imem_pc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h0A;
    mem[1] = 8'h33;
    mem[2] = 8'h4C;
    mem[3] = 8'h75;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    load_mem();
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b0, 1'b0, 8'h00, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset: got %h exp %h", obs,
               {1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_seq();
    logic [7:0] ins [4];
    ins = '{8'h0A, 8'h33, 8'h4C, 8'h75};
    do_reset();
    step();
    checks++;
    if (obs !== {1'b0, 1'b0, 8'h00, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL boot: got %h exp %h", obs,
               {1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a;
      a = 8'(i);
      step();
      checks++;
      if (obs !== {1'b0, 1'b1, ins[i], a, a + 8'd1}) begin
        errors++;
        $display("FAIL seq%0d: got %h exp %h", i, obs,
                 {1'b0, 1'b1, ins[i], a, a + 8'd1});
      end
    end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    step();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs !== {1'b0, 1'b1, 8'h33, 8'h01, 8'h02}) begin
        errors++;
        $display("FAIL stall%0d: got %h exp %h", i, obs,
                 {1'b0, 1'b1, 8'h33, 8'h01, 8'h02});
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (obs !== {1'b0, 1'b1, 8'h4C, 8'h02, 8'h03}) begin
      errors++;
      $display("FAIL unstall: got %h exp %h", obs,
               {1'b0, 1'b1, 8'h4C, 8'h02, 8'h03});
    end
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'h80;
    step();
    checks++;
    if (obs !== {1'b0, 1'b0, 8'h00, 8'h02, 8'h80}) begin
      errors++;
      $display("FAIL redir_stall: got %h exp %h", obs,
               {1'b0, 1'b0, 8'h00, 8'h02, 8'h80});
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    mem[8'h80] = 8'h5A;
    step();
    checks++;
    if (obs !== {1'b0, 1'b1, 8'h5A, 8'h80, 8'h81}) begin
      errors++;
      $display("FAIL redir_tgt: got %h exp %h", obs,
               {1'b0, 1'b1, 8'h5A, 8'h80, 8'h81});
    end
    mem[8'h80] = 8'h00;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    redirect_valid = 1'b1;
    redirect_pc = 8'hFF;
    step();
    checks++;
    if (obs !== {1'b0, 1'b0, 8'h00, 8'h80, 8'hFF}) begin
      errors++;
      $display("FAIL wrap_redir: got %h exp %h", obs,
               {1'b0, 1'b0, 8'h00, 8'h80, 8'hFF});
    end
    redirect_valid = 1'b0;
    step();
    checks++;
    if (obs !== {1'b0, 1'b1, 8'h00, 8'hFF, 8'h00}) begin
      errors++;
      $display("FAIL wrap_ff: got %h exp %h", obs,
               {1'b0, 1'b1, 8'h00, 8'hFF, 8'h00});
    end
    step();
    checks++;
    if (obs !== {1'b0, 1'b1, 8'h00, 8'h00, 8'h01}) begin
      errors++;
      $display("FAIL wrap_00: got %h exp %h", obs,
               {1'b0, 1'b1, 8'h00, 8'h00, 8'h01});
    end
    step();
    checks++;
    if (obs !== {1'b0, 1'b1, 8'h00, 8'h01, 8'h02}) begin
      errors++;
      $display("FAIL wrap_01: got %h exp %h", obs,
               {1'b0, 1'b1, 8'h00, 8'h01, 8'h02});
    end
  endtask

  task automatic test_halt();
    load_mem();
    mem[5] = 8'hFF;
    do_reset();
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (obs !== {1'b1, 1'b1, 8'hFF, 8'h05, 8'h05}) begin
      errors++;
      $display("FAIL halt_cap: got %h exp %h", obs,
               {1'b1, 1'b1, 8'hFF, 8'h05, 8'h05});
    end
    stall = 1'b1;
    step();
    checks++;
    if (obs !== {1'b1, 1'b1, 8'hFF, 8'h05, 8'h05}) begin
      errors++;
      $display("FAIL halt_stall: got %h exp %h", obs,
               {1'b1, 1'b1, 8'hFF, 8'h05, 8'h05});
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== {1'b1, 1'b0, 8'h00, 8'h05, 8'h05}) begin
        errors++;
        $display("FAIL halt_idle%0d: got %h exp %h", i, obs,
                 {1'b1, 1'b0, 8'h00, 8'h05, 8'h05});
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 8'h00;
    step();
    checks++;
    if (obs !== {1'b0, 1'b0, 8'h00, 8'h05, 8'h00}) begin
      errors++;
      $display("FAIL halt_redir: got %h exp %h", obs,
               {1'b0, 1'b0, 8'h00, 8'h05, 8'h00});
    end
    redirect_valid = 1'b0;
    step();
    checks++;
    if (obs !== {1'b0, 1'b1, 8'h0A, 8'h00, 8'h01}) begin
      errors++;
      $display("FAIL halt_resume: got %h exp %h", obs,
               {1'b0, 1'b1, 8'h0A, 8'h00, 8'h01});
    end
  endtask

  task automatic test_async_reset();
    load_mem();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== {1'b0, 1'b0, 8'h00, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL async_rst: got %h exp %h", obs,
               {1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== {1'b0, 1'b0, 8'h00, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL async_boot: got %h exp %h", obs,
               {1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    end
    step();
    checks++;
    if (obs !== {1'b0, 1'b1, 8'h0A, 8'h00, 8'h01}) begin
      errors++;
      $display("FAIL async_first: got %h exp %h", obs,
               {1'b0, 1'b1, 8'h0A, 8'h00, 8'h01});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    load_mem();
    test_reset();
    test_seq();
    test_stall_redirect();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
